// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (optional even parity).
//
// Serialises one byte per accepted request onto 'tx', LSB first, framed by
// one start bit (0) and one stop bit (1). Each bit is held for
// CLKS_PER_BIT = CLK_FREQ / BAUD clock cycles.
//
// Optional feature macro: UART_PARITY_EN
//   When defined, an even-parity bit (^dato) is sent after bit 7 and the
//   frame becomes 11 bit-times. When undefined, the parity state and logic
//   are not compiled and the frame is 10 bit-times.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous reset, active-high
//   dato   in   8  byte to send, sampled on the accepting edge only
//   start  in   1  send request, level-sampled, accepted only when idle
//   tx     out  1  serial line (registered), idles high
//   busy   out  1  high while a frame is in progress
//   done   out  1  high during the final cycle of the stop bit

module uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dato,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (start) begin
                    state_d = S_START;
                    shreg_d = dato;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
`ifdef UART_PARITY_EN
                    parity_d = ^dato;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        // shreg_q[1] is the bit that lands in position 0 after the shift.
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);
    // Decoded from registered state; suppressed while reset is asserted so an
    // aborted frame never reports completion.
    assign done = !rst && (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT = 10.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dato;
    logic       start;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_tx #(
        .CLK_FREQ(50000000),
        .BAUD    (5000000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dato (dato),
        .start(start),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    // bits: line levels in time order (start, d0..d7, stop); par: even parity.
    typedef struct {
        string      name;
        logic [7:0] dato;
        logic [0:9] bits;
        logic       par;
        logic       hold;
        logic       inject;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    task automatic run_frame(input vec_t v);
        logic exp_frame[0:10];
        logic exp_tx;
        for (int i = 0; i < 9; i++) exp_frame[i] = v.bits[i];
`ifdef UART_PARITY_EN
        exp_frame[9]  = v.par;
        exp_frame[10] = 1'b1;
`else
        exp_frame[9]  = v.bits[9];
        exp_frame[10] = 1'b1;
`endif
        dato  = v.dato;
        start = 1'b1;
        for (int j = 0; j <= FL; j++) begin
            @(negedge clk);
            exp_tx = (j < FL) ? exp_frame[j / CPB] : 1'b1;
            chk($sformatf("%s tx c%0d", v.name, j), tx, exp_tx);
            chk($sformatf("%s busy c%0d", v.name, j), busy, (j < FL));
            chk($sformatf("%s done c%0d", v.name, j), done, (j == FL - 1));
            if (j == 0 && !v.hold) begin
                start = 1'b0;
                dato  = ~v.dato;
            end
            if (v.inject && j == 30) begin
                start = 1'b1;
                dato  = 8'hFF;
            end
            if (v.inject && j == 31) start = 1'b0;
        end
        if (!v.hold) begin
            for (int j = 0; j < 15; j++) begin
                @(negedge clk);
                chk($sformatf("%s idle tx %0d", v.name, j), tx, 1'b1);
                chk($sformatf("%s idle busy %0d", v.name, j), busy, 1'b0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{"byte61", 8'h61, 10'b0100001101, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{"byte03", 8'h03, 10'b0110000001, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"b2b00",  8'h00, 10'b0000000001, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"b2bA5",  8'hA5, 10'b0101001011, 1'b0, 1'b0, 1'b0};

        // Reset held with start asserted: nothing may start.
        rst   = 1'b1;
        start = 1'b1;
        dato  = 8'h61;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset tx %0d", i), tx, 1'b1);
            chk($sformatf("reset busy %0d", i), busy, 1'b0);
            chk($sformatf("reset done %0d", i), done, 1'b0);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset tx %0d", i), tx, 1'b1);
            chk($sformatf("post-reset busy %0d", i), busy, 1'b0);
        end

        // Single frames, busy rejection, then a held-start back-to-back pair.
        for (int r = 0; r < 4; r++) run_frame(vecs[r]);

        // Reset in the middle of a frame.
        dato  = 8'h61;
        start = 1'b1;
        for (int j = 0; j <= 45; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
        end
        chk("midreset tx before", tx, 1'b0);
        chk("midreset busy before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset tx", tx, 1'b1);
        chk("midreset busy", busy, 1'b0);
        chk("midreset done", done, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 120; j++) begin
            @(negedge clk);
            chk($sformatf("aborted tx %0d", j), tx, 1'b1);
            chk($sformatf("aborted busy %0d", j), busy, 1'b0);
            chk($sformatf("aborted done %0d", j), done, 1'b0);
        end
        run_frame(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
